// File: rtl/fg_pkg.sv
// Shared types and constants for the DDS function generator tile.
// Build option: define FG_PWM_EN to drive uio_out[7] with a PWM copy of the sample
// instead of the accumulator wrap sync pulse.
package fg_pkg;

  localparam int ACC_W  = 16;  // phase accumulator width
  localparam int OUT_W  = 8;   // sample width, offset binary
  localparam int LUT_AW = 6;   // quarter-wave table address width

  localparam logic [OUT_W-1:0] MIDSCALE    = 8'h80;
  localparam logic [7:0]       UIO_OE_MASK = 8'b1000_0000;

  // Bit positions inside uio_in / uio_out.
  localparam int UIO_WAVE_LSB  = 0;  // [1:0] waveform select
  localparam int UIO_ATTEN_LSB = 2;  // [4:2] attenuation shift
  localparam int UIO_RUN       = 5;
  localparam int UIO_CLEAR     = 6;
  localparam int UIO_SYNC      = 7;  // output: sync pulse or PWM

  typedef enum logic [1:0] {
    WAVE_SINE   = 2'b00,
    WAVE_SQUARE = 2'b01,
    WAVE_TRI    = 2'b10,
    WAVE_SAW    = 2'b11
  } wave_e;

  // Scale an offset-binary sample toward midscale by 2^sh. The arithmetic
  // shift keeps the result inside -128..127, so re-centring never overflows.
  function automatic logic [OUT_W-1:0] attenuate(input logic [OUT_W-1:0] w,
                                                 input logic [2:0]       sh);
    logic signed [OUT_W:0] centered;
    logic signed [OUT_W:0] shifted;
    centered = $signed({1'b0, w}) - $signed({1'b0, MIDSCALE});
    shifted  = centered >>> sh;
    return OUT_W'(shifted + $signed({1'b0, MIDSCALE}));
  endfunction

endpackage

// File: rtl/fg_sine_lut.sv
// Combinational sine shaper: 64-entry quarter-wave magnitude table with
// quadrant mirroring (phase[6]) and inversion about midscale (phase[7]).
module fg_sine_lut
  import fg_pkg::*;
(
  input  logic [7:0]       phase,
  output logic [OUT_W-1:0] sample
);

  // round(127 * sin(pi/2 * (i + 0.5) / 64)), i = 0..63
  localparam logic [6:0] QUARTER [2**LUT_AW] = '{
    7'd2,   7'd5,   7'd8,   7'd11,  7'd14,  7'd17,  7'd20,  7'd23,
    7'd26,  7'd29,  7'd32,  7'd35,  7'd38,  7'd41,  7'd44,  7'd47,
    7'd50,  7'd53,  7'd56,  7'd58,  7'd61,  7'd64,  7'd67,  7'd69,
    7'd72,  7'd74,  7'd77,  7'd79,  7'd82,  7'd84,  7'd86,  7'd89,
    7'd91,  7'd93,  7'd95,  7'd97,  7'd99,  7'd101, 7'd103, 7'd105,
    7'd106, 7'd108, 7'd110, 7'd111, 7'd113, 7'd114, 7'd115, 7'd117,
    7'd118, 7'd119, 7'd120, 7'd121, 7'd122, 7'd123, 7'd124, 7'd124,
    7'd125, 7'd125, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127, 7'd127
  };

  logic [LUT_AW-1:0] idx;
  logic [6:0]        mag;

  // Mirror the index in odd quadrants (63-i == ~i), invert in the lower half.
  always_comb begin
    idx    = phase[6] ? ~phase[LUT_AW-1:0] : phase[LUT_AW-1:0];
    mag    = QUARTER[idx];
    sample = phase[7] ? (8'd127 - {1'b0, mag}) : (8'd128 + {1'b0, mag});
  end

endmodule

// File: rtl/fg_top_dominik_brandstetter.sv
// DDS function generator tile top: 16-bit phase accumulator, sine/square/
// triangle/saw shaping, arithmetic attenuation and a registered 8-bit sample.
// Build option FG_PWM_EN: uio_out[7] carries PWM of the sample; otherwise it
// carries a one-cycle pulse after each accumulator wrap.
module fg_top_dominik_brandstetter
  import fg_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  wave_e            wave_sel;
  logic [2:0]       atten;
  logic             run;
  logic             clear;
  logic [ACC_W:0]   acc_sum;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             wrap_d;
  logic [7:0]       phase;
  logic [OUT_W-1:0] sine_sample;
  logic [OUT_W-1:0] shaped;
  logic [OUT_W-1:0] sample_q, sample_d;
  logic             pin;
  logic             unused_ok;

  // Decode the control fields carried on uio_in.
  always_comb begin
    wave_sel = wave_e'(uio_in[UIO_WAVE_LSB +: 2]);
    atten    = uio_in[UIO_ATTEN_LSB +: 3];
    run      = uio_in[UIO_RUN];
    clear    = uio_in[UIO_CLEAR];
  end

  // Accumulator next state: clear wins over run, run=0 holds the phase.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    acc_sum = {1'b0, acc_q} + {{(ACC_W + 1 - 8){1'b0}}, ui_in};
    acc_d   = acc_q;
    wrap_d  = 1'b0;
    if (clear) begin
      acc_d = '0;
    end else if (run) begin
      acc_d  = acc_sum[ACC_W-1:0];
      wrap_d = acc_sum[ACC_W];
    end
  end

  assign phase = acc_q[ACC_W-1 -: 8];

  fg_sine_lut u_sine_lut (
    .phase  (phase),
    .sample (sine_sample)
  );

  // Waveform select followed by attenuation toward midscale.
  always_comb begin
    shaped = MIDSCALE;
    case (wave_sel)
      WAVE_SINE:   shaped = sine_sample;
      WAVE_SQUARE: shaped = phase[7] ? 8'h00 : 8'hFF;
      WAVE_TRI:    shaped = phase[7] ? (8'hFF - {phase[6:0], 1'b0}) : {phase[6:0], 1'b0};
      WAVE_SAW:    shaped = phase;
    endcase
    sample_d = attenuate(shaped, atten);
  end

  // Accumulator and output sample registers.
  always_ff @(posedge clk or posedge rst_n) begin
    // NOTE: rst_n is active-high on this tile (1 = reset) despite its name.
    if (rst_n) begin
      acc_q    <= '0;
      sample_q <= MIDSCALE;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      acc_q    <= acc_d;
      sample_q <= sample_d;
    end
  end

`ifdef FG_PWM_EN
  logic [7:0] pwm_cnt_q, pwm_cnt_d;
  logic       pwm_q, pwm_d;

  // Free-running PWM counter; pin is high while counter < sample.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 8'd1;
    pwm_d     = (pwm_cnt_q < sample_q);
  end

  // PWM counter and pin register.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      pwm_cnt_q <= '0;
      pwm_q     <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      pwm_q     <= pwm_d;
    end
  end

  assign pin       = pwm_q;
  assign unused_ok = &{1'b0, ena, uio_in[7], wrap_d};
`else
  logic sync_q, sync_d;

  // Sync pulse follows the carry out of an actual add.
  always_comb begin
    sync_d = wrap_d;
  end

  // Sync pulse register.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      sync_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign pin       = sync_q;
  assign unused_ok = &{1'b0, ena, uio_in[7]};
`endif

  // Pin mapping: sample on uo_out, sync/PWM on uio[7] driven as output.
  always_comb begin
    uo_out            = sample_q;
    uio_out           = '0;
    uio_out[UIO_SYNC] = pin;
    uio_oe            = UIO_OE_MASK;
  end

endmodule

// File: tb/tb_fg_top_dominik_brandstetter.sv
// Self-checking bench for the DDS function generator tile. A behavioural model
// (integer phase, $sin-based shaping, floor-division attenuation) is compared
// against the outputs on every falling edge; directed sections pin extremes,
// counts and literal values by hand.
module tb_fg_top_dominik_brandstetter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_checks = 0;
  int n_fail   = 0;
  logic cmp_en = 1'b0;

  localparam real PI = 3.14159265358979;

  fg_top_dominik_brandstetter dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // ---------------- behavioural model ----------------
  function automatic int model_wave(input int p, input int wave);
    int quad, i, q;
    case (wave)
      0: begin
        quad = p / 64;
        i    = p % 64;
        if (quad % 2 == 1) i = 63 - i;
        q = $rtoi(127.0 * $sin(PI / 2.0 * (real'(i) + 0.5) / 64.0) + 0.5);
        return (quad < 2) ? 128 + q : 127 - q;
      end
      1:       return (p < 128) ? 255 : 0;
      2:       return (p < 128) ? 2 * p : 255 - 2 * (p - 128);
      default: return p;
    endcase
  endfunction

  function automatic int model_atten(input int w, input int sh);
    int d, den, q;
    d   = w - 128;
    den = 1 << sh;
    if (d >= 0) q = d / den;
    else        q = -((-d + den - 1) / den);  // floor for negatives
    return q + 128;
  endfunction

  function automatic int model_sample(input int acc, input logic [7:0] cfg);
    return model_atten(model_wave(acc / 256, int'(cfg[1:0])), int'(cfg[4:2]));
  endfunction

  int         m_acc;
  logic [7:0] m_uo;
  logic       m_pin;
`ifdef FG_PWM_EN
  int         m_c;
`endif

  always @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      m_acc <= 0;
      m_uo  <= 8'h80;
      m_pin <= 1'b0;
`ifdef FG_PWM_EN
      m_c   <= 0;
`endif
    end else begin
      m_uo <= 8'(model_sample(m_acc, uio_in));
      if (uio_in[6])      m_acc <= 0;
      else if (uio_in[5]) m_acc <= (m_acc + int'(ui_in)) % 65536;
`ifdef FG_PWM_EN
      m_pin <= (m_c < int'(m_uo));
      m_c   <= (m_c + 1) % 256;
`else
      m_pin <= !uio_in[6] && uio_in[5] && (m_acc + int'(ui_in) > 65535);
`endif
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("uo_out_model", uo_out, m_uo);
      check("uio_out_model", uio_out, {m_pin, 7'b0});
      check("uio_oe_const", uio_oe, 8'h80);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int prev, changes, bad, syncs, wraps, hi, lo, vmax, vmin, v;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h23;  // run, saw, atten 0
    rst_n  = 1'b1;
    #12;
    check("reset_uo", uo_out, 8'h80);
    check("reset_uio_out", uio_out, 8'h00);
    check("reset_uio_oe", uio_oe, 8'h80);
    cmp_en = 1'b1;

    @(posedge clk); #2;
    rst_n = 1'b0;
    wait_cyc(1);
    check("saw_ftw0_first", uo_out, 8'd0);
    wait_cyc(4);
    check("saw_ftw0_static", uo_out, 8'd0);
    check("ftw0_no_sync", uio_out, 8'h00);

    // Saw ramp, FTW=0x80: +1 every 2 cycles, wrap every 512.
    ui_in = 8'h80;
    prev = 0; changes = 0; bad = 0; syncs = 0; wraps = 0;
    for (int i = 0; i < 1030; i++) begin
      wait_cyc(1);
      v = int'(uo_out);
      if (uio_out[7]) syncs++;
      if (v != prev) begin
        changes++;
        if (v != (prev + 1) % 256) bad++;
        if (prev == 255 && v == 0) wraps++;
      end
      prev = v;
    end
    check("saw_changes", changes, 514);
    check("saw_bad_steps", bad, 0);
    check("saw_wraps", wraps, 2);
`ifndef FG_PWM_EN
    check("saw_sync_pulses", syncs, 2);
`endif

    // Square: half period at 255, half at 0.
    uio_in = 8'h21;
    hi = 0; lo = 0;
    for (int i = 0; i < 512; i++) begin
      wait_cyc(1);
      if (uo_out == 8'd255) hi++;
      if (uo_out == 8'd0)   lo++;
    end
    check("square_high_cycles", hi, 256);
    check("square_low_cycles", lo, 256);

    // Triangle, atten 1: extremes 191 / 64.
    uio_in = 8'h26;
    vmax = 0; vmin = 255;
    for (int i = 0; i < 512; i++) begin
      wait_cyc(1);
      if (int'(uo_out) > vmax) vmax = int'(uo_out);
      if (int'(uo_out) < vmin) vmin = int'(uo_out);
    end
    check("tri_att1_max", vmax, 191);
    check("tri_att1_min", vmin, 64);

    // Sine, atten 0: full-scale extremes.
    uio_in = 8'h20;
    vmax = 0; vmin = 255;
    for (int i = 0; i < 512; i++) begin
      wait_cyc(1);
      if (int'(uo_out) > vmax) vmax = int'(uo_out);
      if (int'(uo_out) < vmin) vmin = int'(uo_out);
    end
    check("sine_max", vmax, 255);
    check("sine_min", vmin, 0);

    // Clear with run=1: clear has priority.
    uio_in = 8'h63;
    wait_cyc(2);
    check("clear_saw", uo_out, 8'd0);
    uio_in = 8'h60;
    wait_cyc(1);
    check("clear_sine", uo_out, 8'd130);
    wait_cyc(3);
    check("clear_priority_uo", uo_out, 8'd130);
    check("clear_priority_sync", uio_out, 8'h00);

    // Ramp 20 cycles from zero, then hold.
    uio_in = 8'h23;
    wait_cyc(20);
    check("ramp_20", uo_out, 8'd9);
    uio_in = 8'h03;
    wait_cyc(10);
    check("run0_hold", uo_out, 8'd10);
    ui_in  = 8'h00;
    uio_in = 8'h23;
    wait_cyc(10);
    check("ftw0_frozen", uo_out, 8'd10);

    // Attenuation is arithmetic (floor) on the signed offset.
    uio_in = 8'h3F;  // atten 7
    wait_cyc(1);
    check("atten7_p10", uo_out, 8'd127);
    uio_in = 8'h2F;  // atten 3
    wait_cyc(1);
    check("atten3_p10", uo_out, 8'd113);

`ifdef FG_PWM_EN
    uio_in = 8'h23;
    wait_cyc(2);
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      wait_cyc(1);
      if (uio_out[7]) hi++;
    end
    check("pwm_duty_10", hi, 10);
`endif

    // Async reset mid-waveform, away from any clock edge.
    ui_in  = 8'h80;
    uio_in = 8'h23;
    wait_cyc(50);
    @(posedge clk); #3;
    rst_n = 1'b1;
    #1;
    check("async_reset_uo", uo_out, 8'h80);
    check("async_reset_uio", uio_out, 8'h00);
    #20;
    rst_n = 1'b0;
    wait_cyc(3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
